// File: rtl/pcie_dest_drain.sv
// -----------------------------------------------------------------------------
// pcie_dest_drain
//
// Drain stage behind the PCIe transaction-layer destination FIFOs D0 and D1.
// Pops both FIFOs round-robin, merges the two streams into one ready/valid
// output stream, holds delivered words in a 2-entry in-order queue and keeps
// a saturating delivery counter for each source.
//
// Ports
//   clk         rising-edge clock
//   reset_L     synchronous active-low reset
//   init        synchronous clear of cnt_D0/cnt_D1/sat_err (data path untouched)
//   d0_empty    D0 FIFO empty flag
//   d1_empty    D1 FIFO empty flag
//   data_out0   D0 read data, valid the cycle after pop_D0
//   data_out1   D1 read data, valid the cycle after pop_D1
//   sink_ready  consumer accepts rx_data this cycle
//   pop_D0      pop request to D0 (combinational)
//   pop_D1      pop request to D1 (combinational)
//   rx_data     head word of the output queue
//   rx_valid    rx_data valid
//   rx_src      origin of rx_data: 0=D0, 1=D1
//   cnt_D0      words delivered from D0 (saturating)
//   cnt_D1      words delivered from D1 (saturating)
//   sat_err     sticky: a delivery happened while its counter was at max
//   drain_idle  nothing pending, queue empty, both FIFOs empty
//
// Output queue state machine:
//   state    | meaning
//   Q_EMPTY  | no word held, rx_valid low
//   Q_ONE    | slot 0 holds the head word
//   Q_FULL   | slots 0 and 1 hold words, slot 0 is the older one
// -----------------------------------------------------------------------------
module pcie_dest_drain #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              d0_empty,
  input  logic              d1_empty,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  input  logic              sink_ready,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_src,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1,
  output logic              sat_err,
  output logic              drain_idle
);

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  q_state_t          q_state;
  q_state_t          q_state_nxt;
  logic [DATA_W-1:0] q0_data;
  logic [DATA_W-1:0] q1_data;
  logic [DATA_W-1:0] q0_data_nxt;
  logic [DATA_W-1:0] q1_data_nxt;
  logic              q0_src;
  logic              q1_src;
  logic              q0_src_nxt;
  logic              q1_src_nxt;

  logic              pend;
  logic              pend_src;
  logic              last_grant;

  logic              deliver;
  logic              capture;
  logic [DATA_W-1:0] cap_data;
  logic [2:0]        fill;
  logic              room;
  logic              pop_req;
  logic              grant_src;
  logic              pop_go;

  // Head of the queue is always slot 0.
  assign rx_valid = (q_state != Q_EMPTY);
  assign rx_data  = q0_data;
  assign rx_src   = q0_src;
  assign deliver  = rx_valid & sink_ready;

  // A pop from the previous cycle lands this cycle.
  assign capture  = pend;
  assign cap_data = pend_src ? data_out1 : data_out0;

  // Words held or in flight after this cycle's delivery. The in-flight word
  // is counted here, so a capture always finds a free slot.
  assign fill = {1'b0, q_state} + {2'b00, pend} - {2'b00, deliver};
  assign room = (fill < 3'd2);

  assign drain_idle = ~pend & (q_state == Q_EMPTY) & d0_empty & d1_empty;

  // Round-robin arbiter: on contention grant the source not granted last.
  always_comb begin
    pop_req   = 1'b0;
    grant_src = 1'b0;
    if (!d0_empty && !d1_empty) begin
      pop_req   = 1'b1;
      grant_src = ~last_grant;
    end else if (!d0_empty) begin
      pop_req   = 1'b1;
      grant_src = 1'b0;
    end else if (!d1_empty) begin
      pop_req   = 1'b1;
      grant_src = 1'b1;
    end
    pop_go = reset_L & room & pop_req;
    pop_D0 = pop_go & ~grant_src;
    pop_D1 = pop_go & grant_src;
  end

  // Queue next-state: simultaneous capture and delivery keeps occupancy and
  // shifts the older word to the head before the new word goes to the tail.
  always_comb begin
    q_state_nxt = q_state;
    q0_data_nxt = q0_data;
    q1_data_nxt = q1_data;
    q0_src_nxt  = q0_src;
    q1_src_nxt  = q1_src;
    case (q_state)
      Q_EMPTY: begin
        if (capture) begin
          q0_data_nxt = cap_data;
          q0_src_nxt  = pend_src;
          q_state_nxt = Q_ONE;
        end
      end
      Q_ONE: begin
        if (capture && deliver) begin
          q0_data_nxt = cap_data;
          q0_src_nxt  = pend_src;
        end else if (capture) begin
          q1_data_nxt = cap_data;
          q1_src_nxt  = pend_src;
          q_state_nxt = Q_FULL;
        end else if (deliver) begin
          q_state_nxt = Q_EMPTY;
        end
      end
      Q_FULL: begin
        if (deliver) begin
          q0_data_nxt = q1_data;
          q0_src_nxt  = q1_src;
          if (capture) begin
            q1_data_nxt = cap_data;
            q1_src_nxt  = pend_src;
          end else begin
            q_state_nxt = Q_ONE;
          end
        end
      end
      default: begin
        q_state_nxt = Q_EMPTY;
      end
    endcase
  end

  // Reset drops the pending word and the queue; the FIFOs are not re-read.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      q_state    <= Q_EMPTY;
      q0_data    <= '0;
      q1_data    <= '0;
      q0_src     <= 1'b0;
      q1_src     <= 1'b0;
      pend       <= 1'b0;
      pend_src   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      q_state <= q_state_nxt;
      q0_data <= q0_data_nxt;
      q1_data <= q1_data_nxt;
      q0_src  <= q0_src_nxt;
      q1_src  <= q1_src_nxt;
      pend    <= pop_go;
      if (pop_go) begin
        pend_src   <= grant_src;
        last_grant <= grant_src;
      end
    end
  end

  // Delivery counters; init wins over a same-cycle delivery.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_D0  <= '0;
      cnt_D1  <= '0;
      sat_err <= 1'b0;
    end else if (init) begin
      cnt_D0  <= '0;
      cnt_D1  <= '0;
      sat_err <= 1'b0;
    end else if (deliver) begin
      if (!rx_src) begin
        if (cnt_D0 == CNT_MAX) begin
          sat_err <= 1'b1;
        end else begin
          cnt_D0 <= cnt_D0 + 1'b1;
        end
      end else begin
        if (cnt_D1 == CNT_MAX) begin
          sat_err <= 1'b1;
        end else begin
          cnt_D1 <= cnt_D1 + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcie_dest_drain.sv
module tb_pcie_dest_drain;

  localparam int DW    = 6;
  localparam int CW    = 5;
  localparam int DEPTH = 1024;
  localparam int CMAX  = 31;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          init = 1'b0;
  logic          sink_ready = 1'b0;
  logic          d0_empty;
  logic          d1_empty;
  logic [DW-1:0] data_out0 = '0;
  logic [DW-1:0] data_out1 = '0;
  logic          pop_D0;
  logic          pop_D1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_src;
  logic [CW-1:0] cnt_D0;
  logic [CW-1:0] cnt_D1;
  logic          sat_err;
  logic          drain_idle;

  pcie_dest_drain #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .d0_empty(d0_empty), .d1_empty(d1_empty),
    .data_out0(data_out0), .data_out1(data_out1),
    .sink_ready(sink_ready),
    .pop_D0(pop_D0), .pop_D1(pop_D1),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_src(rx_src),
    .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .sat_err(sat_err),
    .drain_idle(drain_idle)
  );

  always #5 clk = ~clk;

  // Source FIFO models: stimulus writes mem/wr, the pop side owns rd.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0, cyc = 0;

  assign d0_empty = (wr0 == rd0);
  assign d1_empty = (wr1 == rd1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_D0) begin
      data_out0 <= mem0[rd0 % DEPTH];
      rd0 <= rd0 + 1;
    end
    if (pop_D1) begin
      data_out1 <= mem1[rd1 % DEPTH];
      rd1 <= rd1 + 1;
    end
  end

  // Scoreboard: words expected on the output, in order, with the first
  // cycle each may appear as the head.
  logic [DW-1:0] sb_data  [DEPTH];
  logic          sb_src   [DEPTH];
  int            sb_avail [DEPTH];
  int wp = 0, rp = 0;
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model of the pop side: arbitration, room and scoreboard pushes.
  initial begin : producer
    int  m_rd0, m_rd1, infl;
    bit  last_g, ne0, ne1, vld, dlv, g, e0, e1, idle_exp;
    m_rd0 = 0;
    m_rd1 = 0;
    last_g = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_L) begin
        if (cyc > 0) chk("pop_during_reset", int'({pop_D0, pop_D1}), 0);
        last_g = 1'b1;
      end else begin
        ne0  = (wr0 != m_rd0);
        ne1  = (wr1 != m_rd1);
        infl = wp - rp;
        vld  = (infl > 0) && (sb_avail[rp % DEPTH] <= cyc);
        dlv  = vld && sink_ready;
        idle_exp = (infl == 0) && !ne0 && !ne1;
        chk("drain_idle", int'(drain_idle), int'(idle_exp));
        e0 = 1'b0;
        e1 = 1'b0;
        if ((infl - int'(dlv)) < 2 && (ne0 || ne1)) begin
          g = (ne0 && ne1) ? !last_g : ne1;
          if (g) begin
            sb_data[wp % DEPTH] = mem1[m_rd1 % DEPTH];
            m_rd1++;
          end else begin
            sb_data[wp % DEPTH] = mem0[m_rd0 % DEPTH];
            m_rd0++;
          end
          sb_src[wp % DEPTH]   = g;
          sb_avail[wp % DEPTH] = cyc + 2;
          wp++;
          last_g = g;
          e0 = !g;
          e1 = g;
        end
        chk("pop_D0", int'(pop_D0), int'(e0));
        chk("pop_D1", int'(pop_D1), int'(e1));
      end
    end
  end

  // Monitor: compares the output head and counters, retires delivered words.
  initial begin : consumer
    int mc0, mc1;
    bit msat, vld;
    mc0 = 0;
    mc1 = 0;
    msat = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      vld = (rp != wp) && (sb_avail[rp % DEPTH] <= cyc);
      if (cyc > 0) begin
        chk("rx_valid", int'(rx_valid), int'(vld));
        if (vld) begin
          chk("rx_data", int'(rx_data), int'(sb_data[rp % DEPTH]));
          chk("rx_src", int'(rx_src), int'(sb_src[rp % DEPTH]));
        end
        chk("cnt_D0", int'(cnt_D0), mc0);
        chk("cnt_D1", int'(cnt_D1), mc1);
        chk("sat_err", int'(sat_err), int'(msat));
      end
      if (!reset_L) begin
        rp = wp;
        mc0 = 0;
        mc1 = 0;
        msat = 1'b0;
      end else begin
        if (vld && sink_ready) begin
          if (sb_src[rp % DEPTH]) begin
            if (mc1 == CMAX) msat = 1'b1; else mc1++;
          end else begin
            if (mc0 == CMAX) msat = 1'b1; else mc0++;
          end
          rp++;
        end
        if (init) begin
          mc0 = 0;
          mc1 = 0;
          msat = 1'b0;
        end
      end
    end
  end

  task automatic push0(input logic [DW-1:0] v);
    mem0[wr0 % DEPTH] = v;
    wr0++;
  endtask

  task automatic push1(input logic [DW-1:0] v);
    mem1[wr1 % DEPTH] = v;
    wr1++;
  endtask

  // Returns at a negedge with the stage drained.
  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      #4;
      n++;
      if (drain_idle && wr0 == rd0 && wr1 == rd1) break;
    end
    checks++;
    if (!(drain_idle && wr0 == rd0 && wr1 == rd1)) begin
      errors++;
      $display("FAIL drain_timeout: idle=%0d after %0d cycles, expected 1", drain_idle, limit);
    end
    @(negedge clk);
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    reset_L = 1'b1;

    // D0 only, three words back to back
    sink_ready = 1'b1;
    push0(6'h11);
    push0(6'h12);
    push0(6'h13);
    wait_idle(30);
    chk("t1_cnt_D0", int'(cnt_D0), 3);

    // both sources, four words each, alternating grants
    for (int i = 0; i < 4; i++) begin
      push0(6'(8'h20 + i));
      push1(6'(8'h30 + i));
    end
    wait_idle(40);
    chk("t2_cnt_D1", int'(cnt_D1), 4);

    // backpressure with both sources pending
    sink_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push0(6'(8'h01 + i));
      push1(6'(8'h09 + i));
    end
    repeat (8) @(negedge clk);
    sink_ready = 1'b1;
    wait_idle(40);

    // drive D1 counter into saturation
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    for (int i = 0; i < CMAX + 1; i++) push1(6'(i));
    wait_idle(120);
    chk("t4_cnt_D1_sat", int'(cnt_D1), CMAX);
    chk("t4_sat_err", int'(sat_err), 1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("t4_init_cnt_D1", int'(cnt_D1), 0);
    chk("t4_init_sat", int'(sat_err), 0);

    // reset with one word queued and one in flight
    sink_ready = 1'b0;
    push0(6'h05);
    push0(6'h06);
    push0(6'h07);
    push1(6'h3a);
    push1(6'h3b);
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    chk("t5_valid_after_reset", int'(rx_valid), 0);
    sink_ready = 1'b1;
    wait_idle(40);

    // init coincident with a D0 delivery
    push0(6'h2a);
    @(negedge clk);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("t6_cnt_D0", int'(cnt_D0), 0);
    wait_idle(30);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      sink_ready = ($urandom_range(0, 3) != 0);
      init = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) push0(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) == 0) push1(6'($urandom_range(0, 63)));
      @(negedge clk);
    end
    init = 1'b0;
    sink_ready = 1'b1;
    wait_idle(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
